// File: rtl/fetch_unit.sv
// Fetch unit: front end of the 6502 core.
// Owns the program counter, the opcode register and the operand byte latches, and drives the
// memory address. Out of reset it reads the reset vector (low byte, then high byte) into the PC.
// After that it serves control_unit through its strobes.
module fetch_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
    parameter logic [7:0]  NOP_OPCODE   = 8'hEA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        instruction_load,
    input  logic        increment_pc,
    input  logic        pc_load,
    input  logic        operand_lo_load,
    input  logic        operand_hi_load,
    input  logic [1:0]  address_select,
    output logic [15:0] address,
    output logic [7:0]  opcode,
    output logic [7:0]  opcode_reg,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [15:0] pc,
    output logic        ready
);

    typedef enum logic [1:0] {
        StVecLo = 2'd0,
        StVecHi = 2'd1,
        StRun   = 2'd2
    } state_e;

    localparam logic [15:0] VectorHiAddr = RESET_VECTOR + 16'd1;

    localparam logic [1:0] SelPc       = 2'd0;
    localparam logic [1:0] SelZeroPage = 2'd1;
    localparam logic [1:0] SelAbsolute = 2'd2;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  opcode_reg_q, opcode_reg_d;
    logic [7:0]  operand_lo_q, operand_lo_d;
    logic [7:0]  operand_hi_q, operand_hi_d;
    logic        in_run;

    assign in_run = (state_q == StRun);

    // State register; reset restarts the vector sequence from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StVecLo;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: two vector cycles, then RUN until the next reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StVecLo: state_d = StVecHi;
            StVecHi: state_d = StRun;
            StRun:   state_d = StRun;
            default: state_d = StVecLo;
        endcase
    end

    // Datapath registers; reset wins over every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= 16'h0000;
            opcode_reg_q <= NOP_OPCODE;
            operand_lo_q <= 8'h00;
            operand_hi_q <= 8'h00;
        end else begin
            pc_q         <= pc_d;
            opcode_reg_q <= opcode_reg_d;
            operand_lo_q <= operand_lo_d;
            operand_hi_q <= operand_hi_d;
        end
    end

    // Datapath next state: vector bytes into PC, then strobe-driven updates in RUN only.
    always_comb begin
        pc_d         = pc_q;
        opcode_reg_d = opcode_reg_q;
        operand_lo_d = operand_lo_q;
        operand_hi_d = operand_hi_q;
        unique case (state_q)
            StVecLo: pc_d[7:0]  = data_in;
            StVecHi: pc_d[15:8] = data_in;
            StRun: begin
                // Jump uses the operand values held before this edge.
                if (pc_load) begin
                    pc_d = {operand_hi_q, operand_lo_q};
                end else if (increment_pc) begin
                    pc_d = pc_q + 16'd1;
                end
                if (instruction_load) begin
                    opcode_reg_d = data_in;
                end
                if (operand_lo_load) begin
                    operand_lo_d = data_in;
                end
                if (operand_hi_load) begin
                    operand_hi_d = data_in;
                end
            end
            default: ;
        endcase
    end

    // Memory address: vector locations during the sequence, otherwise per address_select.
    always_comb begin
        address = pc_q;
        unique case (state_q)
            StVecLo: address = RESET_VECTOR;
            StVecHi: address = VectorHiAddr;
            StRun: begin
                case (address_select)
                    SelPc:       address = pc_q;
                    SelZeroPage: address = {8'h00, operand_lo_q};
                    SelAbsolute: address = {operand_hi_q, operand_lo_q};
                    default:     address = pc_q;
                endcase
            end
            default: address = pc_q;
        endcase
    end

    // Raw opcode is a NOP until RUN so control_unit idles in FETCH during the vector reads.
    assign opcode     = in_run ? data_in : NOP_OPCODE;
    assign opcode_reg = opcode_reg_q;
    assign operand_lo = operand_lo_q;
    assign operand_hi = operand_hi_q;
    assign pc         = pc_q;
    assign ready      = in_run;

endmodule
